ledpanel_write_sched: RTL and testbench

- Write-side scheduler for the LED panel video memory.
- Shares the single panel write port (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat) between three sources:
  - CPU single-word writes
  - a raster pixel stream (video/network source)
  - an internal rectangle-fill engine
- Sits in the ctrl_clk domain directly in front of the panel driver.
- Emits at most one registered write per cycle.

---
 rtl/ledpanel_pkg.sv | 23 ++
 rtl/ledpanel_write_sched_if.sv | 22 ++
 rtl/ledpanel_fill_engine.sv | 101 ++++++++++
 rtl/ledpanel_write_sched.sv | 142 ++++++++++++++
 tb/tb_ledpanel_write_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ledpanel_pkg.sv
// Shared constants and types for the LED panel write scheduler.
package ledpanel_pkg;

    localparam logic [1:0] REQ_CPU    = 2'd0;
    localparam logic [1:0] REQ_STREAM = 2'd1;
    localparam logic [1:0] REQ_FILL   = 2'd2;

    localparam logic [3:0] WR_RGB = 4'b0111;

    localparam int PANEL_W = 64;
    localparam int PANEL_H = 64;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == REQ_FILL) ? REQ_CPU : idx + 2'd1;
    endfunction

endpackage

// File: rtl/ledpanel_write_sched_if.sv
// CPU write handshake plus the panel write port driven by the scheduler.
interface ledpanel_write_sched_if;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [15:0] cpu_addr;
    logic [2:0]  cpu_wr;
    logic [23:0] cpu_wdat;
    logic        ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;

    modport master (
        input  cpu_valid, cpu_addr, cpu_wr, cpu_wdat,
        output cpu_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );

    modport slave (
        output cpu_valid, cpu_addr, cpu_wr, cpu_wdat,
        input  cpu_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );
endinterface

// File: rtl/ledpanel_fill_engine.sv
// Rectangle-fill engine: walks a latched rectangle row-major, one pixel per grant,
// flagging pixels outside the panel so the caller can drop the strobe.
module ledpanel_fill_engine
    import ledpanel_pkg::*;
#(
    parameter int XW     = 6,
    parameter int X_LAST = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] w,
    input  logic [5:0]    y0,
    input  logic [5:0]    h,
    input  logic [23:0]   color,
    input  logic          gnt,
    output logic          req,
    output logic [15:0]   addr,
    output logic          clip,
    output logic [23:0]   wdat,
    output logic          busy,
    output logic          done
);
    fill_state_e state_r, state_s;
    logic [XW:0] cx_r, x0_r, xlast_r;
    logic [6:0]  cy_r, ylast_r;
    logic [23:0] color_r;
    logic        busy_r, done_r;
    logic        accept_s, row_end_s, last_s;

    // Coordinates carry one extra bit so rectangles may run off the panel edge
    assign accept_s  = (state_r == FILL_IDLE) && start && (w != {XW{1'b0}}) && (h != 6'd0);
    assign row_end_s = (cx_r == xlast_r);
    assign last_s    = row_end_s && (cy_r == ylast_r);

    // Fill FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL_IDLE: begin
                if (accept_s)   state_s = FILL_RUN;
                else if (start) state_s = FILL_DONE;
                else            state_s = FILL_IDLE;
            end
            FILL_RUN: begin
                if (gnt && last_s) state_s = FILL_DONE;
                else               state_s = FILL_RUN;
            end
            FILL_DONE: state_s = FILL_IDLE;
            default:   state_s = FILL_IDLE;
        endcase
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == FILL_RUN);
            done_r  <= (state_s == FILL_DONE);
        end
    end

    // Rectangle latch and row-major pixel stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r    <= {(XW+1){1'b0}};
            xlast_r <= {(XW+1){1'b0}};
            cx_r    <= {(XW+1){1'b0}};
            cy_r    <= 7'd0;
            ylast_r <= 7'd0;
            color_r <= 24'd0;
        end else if (accept_s) begin
            x0_r    <= {1'b0, x0};
            xlast_r <= {1'b0, x0} + {1'b0, w} - (XW+1)'(1);
            cx_r    <= {1'b0, x0};
            cy_r    <= {1'b0, y0};
            ylast_r <= {1'b0, y0} + {1'b0, h} - 7'd1;
            color_r <= color;
        end else if ((state_r == FILL_RUN) && gnt) begin
            if (row_end_s) begin
                cx_r <= x0_r;
                cy_r <= cy_r + 7'd1;
            end else begin
                cx_r <= cx_r + (XW+1)'(1);
            end
        end
    end

    assign req  = busy_r;
    assign addr = 16'({cy_r[5:0], cx_r[XW-1:0]});
    assign clip = (cx_r > (XW+1)'(X_LAST)) || cy_r[6];
    assign wdat = color_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/ledpanel_write_sched.sv
// Write-side scheduler: round-robin shares the panel write port between CPU writes,
// the raster pixel stream and the rectangle-fill engine; one registered write per cycle.
module ledpanel_write_sched
    import ledpanel_pkg::*;
#(
    parameter  int CHAINED = 1,
    parameter  int RR_INIT = 0,
    localparam int XW      = 6 + $clog2(CHAINED)
) (
    input  logic                  ctrl_clk,
    input  logic                  ctrl_rst_n,
    ledpanel_write_sched_if.master bus,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sof,
    input  logic [23:0]           s_data,
    input  logic                  fill_start,
    input  logic [XW-1:0]         fill_x0,
    input  logic [XW-1:0]         fill_w,
    input  logic [5:0]            fill_y0,
    input  logic [5:0]            fill_h,
    input  logic [23:0]           fill_color,
    output logic                  fill_busy,
    output logic                  fill_done
);
    localparam int          X_LAST    = PANEL_W * CHAINED - 1;
    localparam int          AW        = 6 + XW;
    localparam logic [15:0] ADDR_MASK = 16'((32'd1 << AW) - 32'd1);

    logic [2:0]    req_s, gnt_s;
    logic [1:0]    rr_r, idx1_s, idx2_s, win_s;
    logic          any_s;
    logic [5:0]    sy_r, cur_y_s, nxt_y_s;
    logic [XW-1:0] sx_r, cur_x_s, nxt_x_s;
    logic          fill_req_s, fill_clip_s;
    logic [15:0]   fill_addr_s;
    logic [23:0]   fill_wdat_s;
    logic          en_r;
    logic [3:0]    wr_r;
    logic [15:0]   addr_r;
    logic [23:0]   wdat_r;

    ledpanel_fill_engine #(.XW(XW), .X_LAST(X_LAST)) u_fill (
        .clk   (ctrl_clk),
        .rst_n (ctrl_rst_n),
        .start (fill_start),
        .x0    (fill_x0),
        .w     (fill_w),
        .y0    (fill_y0),
        .h     (fill_h),
        .color (fill_color),
        .gnt   (gnt_s[REQ_FILL]),
        .req   (fill_req_s),
        .addr  (fill_addr_s),
        .clip  (fill_clip_s),
        .wdat  (fill_wdat_s),
        .busy  (fill_busy),
        .done  (fill_done)
    );

    assign req_s = {fill_req_s, s_valid, bus.cpu_valid};

    // Round-robin search starting at the priority pointer
    always_comb begin
        idx1_s = rr_next(rr_r);
        idx2_s = rr_next(idx1_s);
        any_s  = 1'b1;
        win_s  = rr_r;
        if (req_s[rr_r])        win_s = rr_r;
        else if (req_s[idx1_s]) win_s = idx1_s;
        else if (req_s[idx2_s]) win_s = idx2_s;
        else begin
            win_s = rr_r;
            any_s = 1'b0;
        end
        gnt_s = any_s ? (3'b001 << win_s) : 3'b000;
    end

    assign bus.cpu_ready = gnt_s[REQ_CPU];
    assign s_ready       = gnt_s[REQ_STREAM];

    // Stream address for this pixel (SOF restarts the frame) and the pointer after it
    always_comb begin
        cur_y_s = s_sof ? 6'd0 : sy_r;
        cur_x_s = s_sof ? {XW{1'b0}} : sx_r;
        if (cur_x_s == XW'(X_LAST)) begin
            nxt_x_s = {XW{1'b0}};
            nxt_y_s = cur_y_s + 6'd1;
        end else begin
            nxt_x_s = cur_x_s + XW'(1);
            nxt_y_s = cur_y_s;
        end
    end

    // Priority pointer and stream pointer advance only on grants
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            rr_r <= 2'(RR_INIT);
            sy_r <= 6'd0;
            sx_r <= {XW{1'b0}};
        end else begin
            if (any_s) rr_r <= rr_next(win_s);
            if (gnt_s[REQ_STREAM]) begin
                sy_r <= nxt_y_s;
                sx_r <= nxt_x_s;
            end
        end
    end

    // Registered panel write; a clipped fill pixel burns its slot with no strobe
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            en_r   <= 1'b0;
            wr_r   <= 4'd0;
            addr_r <= 16'd0;
            wdat_r <= 24'd0;
        end else if (gnt_s[REQ_CPU]) begin
            en_r   <= 1'b1;
            wr_r   <= {1'b0, bus.cpu_wr};
            addr_r <= bus.cpu_addr & ADDR_MASK;
            wdat_r <= bus.cpu_wdat;
        end else if (gnt_s[REQ_STREAM]) begin
            en_r   <= 1'b1;
            wr_r   <= WR_RGB;
            addr_r <= 16'({cur_y_s, cur_x_s});
            wdat_r <= s_data;
        end else if (gnt_s[REQ_FILL] && !fill_clip_s) begin
            en_r   <= 1'b1;
            wr_r   <= WR_RGB;
            addr_r <= fill_addr_s;
            wdat_r <= fill_wdat_s;
        end else begin
            en_r <= 1'b0;
        end
    end

    assign bus.ctrl_en   = en_r;
    assign bus.ctrl_wr   = wr_r;
    assign bus.ctrl_addr = addr_r;
    assign bus.ctrl_wdat = wdat_r;

endmodule

// File: tb/tb_ledpanel_write_sched.sv
// Self-checking bench for ledpanel_write_sched (CHAINED=1, RR_INIT=0): directed scenarios
// plus a randomized mix scored against a queue-based reference model.
module tb_ledpanel_write_sched;
    typedef struct packed {
        logic [15:0] addr;
        logic        clip;
    } fpix_t;

    logic        ctrl_clk = 1'b0;
    logic        ctrl_rst_n;
    logic        s_valid, s_ready, s_sof;
    logic [23:0] s_data;
    logic        fill_start, fill_busy, fill_done;
    logic [5:0]  fill_x0, fill_w, fill_y0, fill_h;
    logic [23:0] fill_color;
    int          checks = 0;
    int          errors = 0;

    ledpanel_write_sched_if bus ();

    ledpanel_write_sched #(.CHAINED(1), .RR_INIT(0)) dut (
        .ctrl_clk   (ctrl_clk),
        .ctrl_rst_n (ctrl_rst_n),
        .bus        (bus),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .s_data     (s_data),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_w     (fill_w),
        .fill_y0    (fill_y0),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.cpu_valid = 1'b0; bus.cpu_addr = 16'd0; bus.cpu_wr = 3'd0; bus.cpu_wdat = 24'd0;
        s_valid = 1'b0; s_sof = 1'b0; s_data = 24'd0;
        fill_start = 1'b0; fill_x0 = 6'd0; fill_w = 6'd0; fill_y0 = 6'd0; fill_h = 6'd0;
        fill_color = 24'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ctrl_rst_n = 1'b0;
        repeat (2) @(negedge ctrl_clk);
        ctrl_rst_n = 1'b1;
        @(negedge ctrl_clk);
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        ctrl_rst_n = 1'b0;
        @(negedge ctrl_clk);
        checks++;
        if ({bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat, fill_busy, fill_done,
             bus.cpu_ready, s_ready} !== 52'd0) begin
            errors++;
            $display("FAIL reset_state: en=%0b wr=%h addr=%h wdat=%h busy=%0b done=%0b, want all 0",
                     bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat, fill_busy, fill_done);
        end
        ctrl_rst_n = 1'b1;
        @(negedge ctrl_clk);
        // 4x4 fill, reset after the fifth write
        fill_start = 1'b1; fill_x0 = 6'd4; fill_y0 = 6'd4; fill_w = 6'd4; fill_h = 6'd4;
        fill_color = 24'h00FF00;
        @(negedge ctrl_clk);
        fill_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            @(negedge ctrl_clk);
            if (bus.ctrl_en) n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL midfill_writes: got %0d writes, want 5", n);
        end
        #2 ctrl_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat, fill_busy, fill_done} !== 50'd0) begin
            errors++;
            $display("FAIL async_reset: en=%0b addr=%h wdat=%h busy=%0b, want all 0",
                     bus.ctrl_en, bus.ctrl_addr, bus.ctrl_wdat, fill_busy);
        end
        @(negedge ctrl_clk);
        ctrl_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ctrl_clk);
            checks++;
            if ({bus.ctrl_en, fill_busy, fill_done} !== 3'b000) begin
                errors++;
                $display("FAIL after_reset_quiet: en=%0b busy=%0b done=%0b at cycle %0d, want 000",
                         bus.ctrl_en, fill_busy, fill_done, i);
            end
        end
    endtask

    task automatic test_cpu_single();
        bus.cpu_valid = 1'b1; bus.cpu_addr = 16'h0805; bus.cpu_wr = 3'b101; bus.cpu_wdat = 24'h112233;
        #1;
        checks++;
        if ({bus.cpu_ready, s_ready} !== 2'b10) begin
            errors++;
            $display("FAIL cpu_ready: got cpu=%0b s=%0b, want 1 0", bus.cpu_ready, s_ready);
        end
        @(negedge ctrl_clk);
        bus.cpu_valid = 1'b0;
        checks++;
        if ({bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat} !== {1'b1, 4'b0101, 16'h0805, 24'h112233}) begin
            errors++;
            $display("FAIL cpu_write: en=%0b wr=%b addr=%h wdat=%h, want 1 0101 0805 112233",
                     bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat);
        end
        @(negedge ctrl_clk);
        checks++;
        if ({bus.ctrl_en, bus.ctrl_addr} !== {1'b0, 16'h0805}) begin
            errors++;
            $display("FAIL cpu_idle_hold: en=%0b addr=%h, want 0 0805", bus.ctrl_en, bus.ctrl_addr);
        end
    endtask

    task automatic test_stream();
        int          ptr;
        logic [15:0] exp_a;
        logic [23:0] d;
        ptr = 0;
        for (int i = 0; i < 4109; i++) begin
            s_valid = 1'b1;
            s_sof   = (i == 0) || (i == 4107);
            s_data  = 24'($urandom);
            d       = s_data;
            if (s_sof) begin
                exp_a = 16'd0;
                ptr   = 1;
            end else begin
                exp_a = 16'(ptr);
                ptr   = (ptr + 1) % 4096;
            end
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: got %0b want 1 at pixel %0d", s_ready, i);
            end
            @(negedge ctrl_clk);
            checks++;
            if ({bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat} !== {1'b1, 4'b0111, exp_a, d}) begin
                errors++;
                $display("FAIL stream_write px%0d: en=%0b wr=%b addr=%h wdat=%h, want 1 0111 %h %h",
                         i, bus.ctrl_en, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat, exp_a, d);
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge ctrl_clk);
        checks++;
        if (bus.ctrl_en !== 1'b0) begin
            errors++;
            $display("FAIL stream_stop: en=%0b want 0", bus.ctrl_en);
        end
    endtask

    task automatic test_fill_clip();
        logic        e_en;
        logic [15:0] e_a;
        fill_start = 1'b1; fill_x0 = 6'd62; fill_y0 = 6'd63; fill_w = 6'd4; fill_h = 6'd2;
        fill_color = 24'hFF0000;
        @(negedge ctrl_clk);
        fill_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            e_en = (k == 2) || (k == 3);
            e_a  = (k == 2) ? 16'h0FFE : 16'h0FFF;
            checks++;
            if ({fill_busy, fill_done, bus.ctrl_en} !== {(k <= 8), (k == 9), e_en}) begin
                errors++;
                $display("FAIL fill_clip_seq k=%0d: busy=%0b done=%0b en=%0b, want %0b %0b %0b",
                         k, fill_busy, fill_done, bus.ctrl_en, (k <= 8), (k == 9), e_en);
            end
            if (e_en) begin
                checks++;
                if ({bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat} !== {4'b0111, e_a, 24'hFF0000}) begin
                    errors++;
                    $display("FAIL fill_clip_write k=%0d: wr=%b addr=%h wdat=%h, want 0111 %h ff0000",
                             k, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat, e_a);
                end
            end
            @(negedge ctrl_clk);
        end
    endtask

    task automatic test_back_to_back_rr();
        int          cnt[3];
        logic [23:0] e_d;
        cnt = '{0, 0, 0};
        do_reset();
        fill_start = 1'b1; fill_x0 = 6'd0; fill_y0 = 6'd0; fill_w = 6'd63; fill_h = 6'd63;
        fill_color = 24'hC0FFEE;
        @(negedge ctrl_clk);
        fill_start = 1'b0;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 16'h0123; bus.cpu_wr = 3'b111; bus.cpu_wdat = 24'hAAAAAA;
        s_valid = 1'b1; s_data = 24'h555555;
        for (int j = 0; j < 30; j++) begin
            #1;
            checks++;
            if ({bus.cpu_ready, s_ready} !== {(j % 3 == 0), (j % 3 == 1)}) begin
                errors++;
                $display("FAIL rr_grant j=%0d: cpu=%0b s=%0b, want %0b %0b",
                         j, bus.cpu_ready, s_ready, (j % 3 == 0), (j % 3 == 1));
            end
            @(negedge ctrl_clk);
            e_d = (j % 3 == 0) ? 24'hAAAAAA : (j % 3 == 1) ? 24'h555555 : 24'hC0FFEE;
            checks++;
            if ({bus.ctrl_en, bus.ctrl_wdat} !== {1'b1, e_d}) begin
                errors++;
                $display("FAIL rr_write j=%0d: en=%0b wdat=%h, want 1 %h", j, bus.ctrl_en, bus.ctrl_wdat, e_d);
            end
            if (bus.ctrl_en === 1'b1) begin
                if (bus.ctrl_wdat === 24'hAAAAAA) cnt[0]++;
                else if (bus.ctrl_wdat === 24'h555555) cnt[1]++;
                else if (bus.ctrl_wdat === 24'hC0FFEE) cnt[2]++;
            end
        end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (cnt[s] != 10) begin
                errors++;
                $display("FAIL rr_share src%0d: got %0d grants, want 10", s, cnt[s]);
            end
        end
        do_reset();
    endtask

    task automatic test_fill_noop_restart();
        int          dc, ec, bc, n;
        logic [15:0] e_a;
        fill_start = 1'b1; fill_x0 = 6'd3; fill_y0 = 6'd3; fill_w = 6'd0; fill_h = 6'd5;
        @(negedge ctrl_clk);
        fill_start = 1'b0;
        dc = 0; ec = 0; bc = 0;
        for (int i = 0; i < 4; i++) begin
            if (fill_done) dc++;
            if (bus.ctrl_en) ec++;
            if (fill_busy) bc++;
            @(negedge ctrl_clk);
        end
        checks++;
        if ({dc, ec, bc} !== {32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL fill_noop: done=%0d en=%0d busy=%0d, want 1 0 0", dc, ec, bc);
        end
        fill_start = 1'b1; fill_x0 = 6'd10; fill_y0 = 6'd20; fill_w = 6'd3; fill_h = 6'd2;
        fill_color = 24'h00AA55;
        @(negedge ctrl_clk);
        dc = 0; n = 0;
        for (int i = 0; i < 15; i++) begin
            if (fill_done) dc++;
            if (bus.ctrl_en) begin
                e_a = 16'((20 + n / 3) * 64 + 10 + n % 3);
                checks++;
                if ({bus.ctrl_addr, bus.ctrl_wdat} !== {e_a, 24'h00AA55}) begin
                    errors++;
                    $display("FAIL fill_restart_write %0d: addr=%h wdat=%h, want %h 00aa55",
                             n, bus.ctrl_addr, bus.ctrl_wdat, e_a);
                end
                n++;
            end
            if (i == 0) begin
                fill_start = 1'b1; fill_x0 = 6'd0; fill_y0 = 6'd0; fill_w = 6'd1; fill_h = 6'd1;
                fill_color = 24'h123456;
            end else begin
                fill_start = 1'b0;
            end
            @(negedge ctrl_clk);
        end
        checks++;
        if ({n, dc} !== {32'd6, 32'd1}) begin
            errors++;
            $display("FAIL fill_restart_count: writes=%0d done=%0d, want 6 1", n, dc);
        end
    endtask

    task automatic test_random_mix();
        fpix_t       fq[$];
        fpix_t       p;
        int          rr, sptr, fphase, fnext, win;
        logic [2:0]  reqs;
        logic        cpu_pend, e_en;
        logic [3:0]  e_wr;
        logic [15:0] e_a;
        logic [23:0] e_d, fcol;
        do_reset();
        rr = 0; sptr = 0; fphase = 0; cpu_pend = 1'b0; fcol = 24'd0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!cpu_pend) begin
                bus.cpu_valid = 1'($urandom_range(1, 0));
                bus.cpu_addr  = 16'($urandom);
                bus.cpu_wr    = 3'($urandom);
                bus.cpu_wdat  = 24'($urandom);
                cpu_pend      = bus.cpu_valid;
            end
            s_valid    = 1'($urandom_range(1, 0));
            s_sof      = ($urandom_range(15, 0) == 0);
            s_data     = 24'($urandom);
            fill_start = ($urandom_range(20, 0) == 0);
            fill_x0    = 6'($urandom_range(63, 0));
            fill_y0    = 6'($urandom_range(63, 0));
            fill_w     = 6'($urandom_range(7, 0));
            fill_h     = 6'($urandom_range(3, 0));
            fill_color = 24'($urandom);
            reqs = {(fphase == 1), s_valid, bus.cpu_valid};
            win = -1;
            for (int k = 0; k < 3; k++)
                if (win < 0 && reqs[(rr + k) % 3]) win = (rr + k) % 3;
            #1;
            checks++;
            if ({bus.cpu_ready, s_ready} !== {(win == 0), (win == 1)}) begin
                errors++;
                $display("FAIL rand_grant cyc=%0d: cpu=%0b s=%0b, want %0b %0b",
                         cyc, bus.cpu_ready, s_ready, (win == 0), (win == 1));
            end
            e_en = 1'b0; e_wr = 4'b0111; e_a = 16'd0; e_d = 24'd0;
            fnext = fphase;
            if (win == 0) begin
                e_en = 1'b1; e_wr = {1'b0, bus.cpu_wr}; e_a = bus.cpu_addr & 16'h0FFF; e_d = bus.cpu_wdat;
                cpu_pend = 1'b0;
            end else if (win == 1) begin
                if (s_sof) sptr = 0;
                e_en = 1'b1; e_a = 16'(sptr); e_d = s_data;
                sptr = (sptr + 1) % 4096;
            end else if (win == 2) begin
                p = fq.pop_front();
                e_en = !p.clip; e_a = p.addr; e_d = fcol;
                if (fq.size() == 0) fnext = 2;
            end
            if (fphase == 2) fnext = 0;
            if (fphase == 0 && fill_start) begin
                if (fill_w != 6'd0 && fill_h != 6'd0) begin
                    for (int yy = int'(fill_y0); yy < int'(fill_y0) + int'(fill_h); yy++)
                        for (int xx = int'(fill_x0); xx < int'(fill_x0) + int'(fill_w); xx++)
                            fq.push_back('{addr: 16'(yy * 64 + xx), clip: (xx > 63) || (yy > 63)});
                    fcol  = fill_color;
                    fnext = 1;
                end else begin
                    fnext = 2;
                end
            end
            if (win >= 0) rr = (win + 1) % 3;
            fphase = fnext;
            @(negedge ctrl_clk);
            bus.cpu_valid = cpu_pend;
            checks++;
            if ({bus.ctrl_en, fill_busy, fill_done} !== {e_en, (fphase == 1), (fphase == 2)}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d: en=%0b busy=%0b done=%0b, want %0b %0b %0b",
                         cyc, bus.ctrl_en, fill_busy, fill_done, e_en, (fphase == 1), (fphase == 2));
            end
            if (e_en) begin
                checks++;
                if ({bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat} !== {e_wr, e_a, e_d}) begin
                    errors++;
                    $display("FAIL rand_write cyc=%0d: wr=%b addr=%h wdat=%h, want %b %h %h",
                             cyc, bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat, e_wr, e_a, e_d);
                end
            end
        end
        idle_inputs();
        @(negedge ctrl_clk);
    endtask

    initial begin
        test_reset();
        test_cpu_single();
        test_stream();
        test_fill_clip();
        test_back_to_back_rr();
        test_fill_noop_restart();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
